// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared widths, sizes and FSM state type for the weight fetch controller
package ann_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int N_WEIGHTS = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } wfc_state_t;
endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// rtl/weight_fetch_ctrl_if.sv - weight stream (valid/ready, data, idx, last) towards the neuron MAC
interface weight_fetch_ctrl_if
  import ann_pkg::*;
  ();
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_idx;
  logic              w_last;

  modport master (output w_valid, output w_data, output w_idx, output w_last, input w_ready);
  modport slave  (input w_valid, input w_data, input w_idx, input w_last, output w_ready);
endinterface

// File: rtl/wfc_skid_buf.sv
// rtl/wfc_skid_buf.sv - 2-entry FIFO carrying {data, idx, last} with valid/ready on both sides
module wfc_skid_buf
  import ann_pkg::*;
  #(parameter int W = DATA_W + ADDR_W + 1)
  (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic         wr_sel;
  logic         rd_sel;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_sel];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage, pointers and occupancy; reset empties the buffer and zeroes entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_sel] <= in_data;
        wr_sel      <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - owns the weight BRAM port: host writes in IDLE, read sweep to the MAC; WFC_ADDR_CHECK_EN adds the load range check and ld_err
module weight_fetch_ctrl
  import ann_pkg::*;
  (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  weight_fetch_ctrl_if.master        w,
  output logic [ADDR_W-1:0]          bram_addr,
  output logic [DATA_W-1:0]          bram_di,
  output logic                       bram_en,
  output logic                       bram_we,
`ifdef WFC_ADDR_CHECK_EN
  output logic                       ld_err,
`endif
  input  logic [DATA_W-1:0]          bram_do
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WEIGHTS - 1);
  localparam int SKID_W = DATA_W + ADDR_W + 1;

  wfc_state_t        state;
  wfc_state_t        state_nxt;
  logic [ADDR_W-1:0] rd_ptr;
  logic              issue;
  logic              ld_fire;
  logic              wr_ok;
  logic              skid_in_ready;
  logic              skid_out_valid;
  logic [SKID_W-1:0] skid_in;
  logic [SKID_W-1:0] skid_out;

  // Host loads only in IDLE and never in the cycle a sweep is requested
  assign ld_ready = RST_N && (state == IDLE) && !start;
  assign ld_fire  = ld_valid && ld_ready;

`ifdef WFC_ADDR_CHECK_EN
  assign wr_ok = ld_fire && (ld_addr <= LAST_IDX);

  // Sticky flag for an out-of-range load; only reset clears it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ld_err <= 1'b0;
    end else if (ld_fire && (ld_addr > LAST_IDX)) begin
      ld_err <= 1'b1;
    end
  end
`else
  assign wr_ok = ld_fire;
`endif

  // State register and read pointer; the pointer wraps to 0 after the last issue
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Next state and read issue; a read goes out only when the skid has room for its data
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        if (skid_in_ready) begin
          issue = 1'b1;
          if (rd_ptr == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!skid_out_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == FETCH) || (state == DRAIN);
  assign done = (state == DRAIN) && !skid_out_valid;

  // BRAM reads on the negedge of the issue cycle, so DO is valid at the closing posedge
  assign bram_en   = issue || wr_ok;
  assign bram_we   = wr_ok;
  assign bram_addr = issue ? rd_ptr : (wr_ok ? ld_addr : '0);
  assign bram_di   = wr_ok ? ld_data : '0;

  assign skid_in = {bram_do, rd_ptr, (rd_ptr == LAST_IDX)};

  wfc_skid_buf #(.W(SKID_W)) u_skid (
    .clk       (CLK),
    .rst_n     (RST_N),
    .in_valid  (issue),
    .in_ready  (skid_in_ready),
    .in_data   (skid_in),
    .out_valid (skid_out_valid),
    .out_ready (w.w_ready),
    .out_data  (skid_out)
  );

  assign w.w_valid = skid_out_valid;
  assign {w.w_data, w.w_idx, w.w_last} = skid_out;
endmodule
